hartslag_evaluatie: RTL and testbench

HARTSLAG_EVALUATIE -- requirements
Module: hartslag_evaluatie

---
 rtl/hartslag_pkg.sv | 25 ++
 rtl/gemiddelde_buffer.sv | 86 ++++++++
 rtl/hartslag_evaluatie.sv | 141 ++++++++++++++
 tb/tb_hartslag_evaluatie.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hartslag_pkg.sv
// -----------------------------------------------------------------------------
// hartslag_pkg
// Shared definitions for the heart-rate evaluation block:
//   - toestand_t : heart-rate state encoding (LAAG / NORMAAL / HOOG)
//   - BUF_DIEPTE : depth of the moving-average window (4 entries)
//   - VUL_VOL    : fill-counter value that marks a full window
//   - som_naar_gem() : running sum -> truncated average over 4 entries
// -----------------------------------------------------------------------------
package hartslag_pkg;

    typedef enum logic [1:0] {
        TOESTAND_LAAG    = 2'b00,
        TOESTAND_NORMAAL = 2'b01,
        TOESTAND_HOOG    = 2'b10
    } toestand_t;

    localparam int          BUF_DIEPTE = 4;
    localparam logic [2:0]  VUL_VOL    = 3'd4;

    // Division by the window depth of 4 is a plain right shift by two.
    function automatic logic [7:0] som_naar_gem(input logic [9:0] som);
        return som[9:2];
    endfunction

endpackage

// File: rtl/gemiddelde_buffer.sv
// -----------------------------------------------------------------------------
// gemiddelde_buffer
// Four-entry ring buffer of window beat counts with a running sum and a fill
// counter. Once four samples are held, every accepted sample produces a
// registered average and a one-cycle valid strobe.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   slagen_in   in   8-bit beat count of the window that just closed
//   slagen_vld  in   one-cycle strobe qualifying slagen_in
//   gemiddelde  out  8-bit registered moving average (0 until window full)
//   gem_vld     out  one-cycle strobe, gemiddelde just updated
// -----------------------------------------------------------------------------
module gemiddelde_buffer
    import hartslag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] slagen_in,
    input  logic       slagen_vld,
    output logic [7:0] gemiddelde,
    output logic       gem_vld
);

    logic [BUF_DIEPTE-1:0][7:0] buf_q, buf_d;
    logic [9:0]                 som_q, som_d;
    logic [1:0]                 wr_ptr_q, wr_ptr_d;
    logic [2:0]                 vul_q, vul_d;
    logic [7:0]                 gem_q, gem_d;
    logic                       gem_vld_q, gem_vld_d;

    // Next-state logic for buffer, running sum, pointer, fill count and outputs.
    always_comb begin
        buf_d     = buf_q;
        som_d     = som_q;
        wr_ptr_d  = wr_ptr_q;
        vul_d     = vul_q;
        gem_d     = gem_q;
        gem_vld_d = 1'b0;
        if (slagen_vld) begin
            buf_d[wr_ptr_q] = slagen_in;
            // The intermediate subtraction may wrap, but the final sum of
            // four 8-bit entries always fits in 10 bits.
            som_d    = som_q - {2'b00, buf_q[wr_ptr_q]} + {2'b00, slagen_in};
            wr_ptr_d = wr_ptr_q + 2'd1;
            if (vul_q != VUL_VOL) begin
                vul_d = vul_q + 3'd1;
            end else begin
                vul_d = vul_q;
            end
            if (vul_d == VUL_VOL) begin
                gem_d     = som_naar_gem(som_d);
                gem_vld_d = 1'b1;
            end else begin
                gem_d     = gem_q;
                gem_vld_d = 1'b0;
            end
        end else begin
            gem_vld_d = 1'b0;
        end
    end

    // State register; reset wins over a coincident strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q     <= '0;
            som_q     <= 10'd0;
            wr_ptr_q  <= 2'd0;
            vul_q     <= 3'd0;
            gem_q     <= 8'd0;
            gem_vld_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            som_q     <= som_d;
            wr_ptr_q  <= wr_ptr_d;
            vul_q     <= vul_d;
            gem_q     <= gem_d;
            gem_vld_q <= gem_vld_d;
        end
    end

    assign gemiddelde = gem_q;
    assign gem_vld    = gem_vld_q;

endmodule

// File: rtl/hartslag_evaluatie.sv
// -----------------------------------------------------------------------------
// hartslag_evaluatie
// Heart-rate evaluation: moving average over the last four measurement
// windows, LAAG/NORMAAL/HOOG classification with hysteresis on leaving an
// abnormal state, and an alarm after ALARM_N consecutive abnormal evaluations.
//
// Parameters:
//   LAAG_GRENS  lower beats-per-window threshold
//   HOOG_GRENS  upper beats-per-window threshold
//   HYST        hysteresis margin when leaving LAAG or HOOG
//   ALARM_N     consecutive non-NORMAAL evaluations before alarm
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   slagen_in   in   8-bit beat count of the window that just closed
//   slagen_vld  in   one-cycle strobe qualifying slagen_in
//   gemiddelde  out  8-bit moving average of the last 4 windows
//   gem_vld     out  one-cycle strobe, gemiddelde updated
//   toestand    out  00 LAAG, 01 NORMAAL, 10 HOOG
//   alarm       out  level, sustained abnormal rate
// -----------------------------------------------------------------------------
module hartslag_evaluatie
    import hartslag_pkg::*;
#(
    parameter int LAAG_GRENS = 25,
    parameter int HOOG_GRENS = 45,
    parameter int HYST       = 2,
    parameter int ALARM_N    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] slagen_in,
    input  logic       slagen_vld,
    output logic [7:0] gemiddelde,
    output logic       gem_vld,
    output logic [1:0] toestand,
    output logic       alarm
);

    if (!((LAAG_GRENS + HYST) < (HOOG_GRENS - HYST)) || (ALARM_N < 1)) begin : g_param_check
        $error("hartslag_evaluatie: need LAAG_GRENS+HYST < HOOG_GRENS-HYST and ALARM_N >= 1");
    end

    localparam int         CNT_W      = $clog2(ALARM_N + 1);
    localparam logic [9:0] LAAG_L     = 10'(LAAG_GRENS);
    localparam logic [9:0] HOOG_L     = 10'(HOOG_GRENS);
    localparam logic [9:0] LAAG_UIT_L = 10'(LAAG_GRENS + HYST);
    localparam logic [9:0] HOOG_UIT_L = 10'(HOOG_GRENS - HYST);
    localparam logic [CNT_W-1:0] ALARM_MAX = CNT_W'(ALARM_N);

    logic [7:0]       gem_s;
    logic             gem_vld_s;
    logic [9:0]       gem_ext_s;

    toestand_t        toestand_q, toestand_d;
    logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic             alarm_q, alarm_d;

    gemiddelde_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .slagen_in  (slagen_in),
        .slagen_vld (slagen_vld),
        .gemiddelde (gem_s),
        .gem_vld    (gem_vld_s)
    );

    assign gem_ext_s = {2'b00, gem_s};

    // State / alarm next-state logic, evaluated only while a fresh average is valid.
    always_comb begin
        toestand_d  = toestand_q;
        alarm_cnt_d = alarm_cnt_q;
        alarm_d     = alarm_q;
        if (gem_vld_s) begin
            case (toestand_q)
                TOESTAND_NORMAAL: begin
                    if (gem_ext_s > HOOG_L) begin
                        toestand_d = TOESTAND_HOOG;
                    end else if (gem_ext_s < LAAG_L) begin
                        toestand_d = TOESTAND_LAAG;
                    end else begin
                        toestand_d = TOESTAND_NORMAAL;
                    end
                end
                TOESTAND_HOOG: begin
                    if (gem_ext_s < LAAG_L) begin
                        toestand_d = TOESTAND_LAAG;
                    end else if (gem_ext_s < HOOG_UIT_L) begin
                        toestand_d = TOESTAND_NORMAAL;
                    end else begin
                        toestand_d = TOESTAND_HOOG;
                    end
                end
                TOESTAND_LAAG: begin
                    if (gem_ext_s > HOOG_L) begin
                        toestand_d = TOESTAND_HOOG;
                    end else if (gem_ext_s > LAAG_UIT_L) begin
                        toestand_d = TOESTAND_NORMAAL;
                    end else begin
                        toestand_d = TOESTAND_LAAG;
                    end
                end
                default: begin
                    toestand_d = TOESTAND_NORMAAL;
                end
            endcase
            // Any abnormal outcome (including a direct LAAG<->HOOG jump) keeps counting.
            if (toestand_d == TOESTAND_NORMAAL) begin
                alarm_cnt_d = '0;
            end else if (alarm_cnt_q != ALARM_MAX) begin
                alarm_cnt_d = alarm_cnt_q + CNT_W'(1);
            end else begin
                alarm_cnt_d = alarm_cnt_q;
            end
            alarm_d = (alarm_cnt_d == ALARM_MAX);
        end else begin
            alarm_d = alarm_q;
        end
    end

    // State, alarm counter and alarm registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            toestand_q  <= TOESTAND_NORMAAL;
            alarm_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            toestand_q  <= toestand_d;
            alarm_cnt_q <= alarm_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    assign gemiddelde = gem_s;
    assign gem_vld    = gem_vld_s;
    assign toestand   = toestand_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_hartslag_evaluatie.sv
// -----------------------------------------------------------------------------
// tb_hartslag_evaluatie
// Directed scenarios followed by random stimulus, compared cycle by cycle
// against a window/threshold model of the heart-rate evaluation.
// -----------------------------------------------------------------------------
module tb_hartslag_evaluatie;

    localparam int LG = 25;
    localparam int HG = 45;
    localparam int HY = 2;
    localparam int AN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] slagen_in = 8'd0;
    logic       slagen_vld = 1'b0;
    logic [7:0] gemiddelde;
    logic       gem_vld;
    logic [1:0] toestand;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    // Reference model: last four samples, last average, state (0 LAAG,
    // 1 NORMAAL, 2 HOOG) and number of consecutive abnormal evaluations.
    int venster[$];
    int m_gem = 0;
    bit m_vld = 1'b0;
    int m_toe = 1;
    int m_cnt = 0;

    always #5 clk = ~clk;

    hartslag_evaluatie #(
        .LAAG_GRENS (LG),
        .HOOG_GRENS (HG),
        .HYST       (HY),
        .ALARM_N    (AN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .slagen_in  (slagen_in),
        .slagen_vld (slagen_vld),
        .gemiddelde (gemiddelde),
        .gem_vld    (gem_vld),
        .toestand   (toestand),
        .alarm      (alarm)
    );

    task automatic controleer(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge.
    task automatic model_flank(input bit rst, input bit vld, input int val);
        int nieuw;
        int s;
        if (rst) begin
            venster.delete();
            m_gem = 0;
            m_vld = 1'b0;
            m_toe = 1;
            m_cnt = 0;
        end else begin
            if (m_vld) begin
                nieuw = m_toe;
                if (m_toe == 1) begin
                    if (m_gem > HG) nieuw = 2;
                    else if (m_gem < LG) nieuw = 0;
                end else if (m_toe == 2) begin
                    if (m_gem < LG) nieuw = 0;
                    else if (m_gem < HG - HY) nieuw = 1;
                end else begin
                    if (m_gem > HG) nieuw = 2;
                    else if (m_gem > LG + HY) nieuw = 1;
                end
                m_toe = nieuw;
                if (nieuw == 1) m_cnt = 0;
                else if (m_cnt < AN) m_cnt++;
            end
            m_vld = 1'b0;
            if (vld) begin
                venster.push_back(val);
                if (venster.size() > 4) void'(venster.pop_front());
                if (venster.size() == 4) begin
                    s = 0;
                    foreach (venster[i]) s += venster[i];
                    m_gem = s / 4;
                    m_vld = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: drive, let the edge happen, then compare all outputs.
    task automatic stap(input bit rst, input bit vld, input int val);
        reset      = rst;
        slagen_vld = vld;
        slagen_in  = 8'(val);
        @(posedge clk);
        model_flank(rst, vld, val);
        @(negedge clk);
        controleer("gem_vld",    10'(gem_vld),    10'(m_vld));
        controleer("gemiddelde", 10'(gemiddelde), 10'(m_gem));
        controleer("toestand",   10'(toestand),   10'(m_toe));
        controleer("alarm",      10'(alarm),      10'(m_cnt == AN));
        reset      = 1'b0;
        slagen_vld = 1'b0;
    endtask

    task automatic strobes(input int val, input int n);
        for (int i = 0; i < n; i++) stap(1'b0, 1'b1, val);
    endtask

    initial begin
        // Reset state.
        stap(1'b1, 1'b0, 0);
        stap(1'b1, 1'b0, 0);
        controleer("reset_toestand_normaal", 10'(toestand), 10'd1);

        // Three strobes of 30 give nothing, the fourth gives an average of 30.
        strobes(30, 3);
        controleer("geen_gem_vld_na_3", 10'(gem_vld), 10'd0);
        stap(1'b0, 1'b1, 30);
        controleer("gem_30", 10'(gemiddelde), 10'd30);
        stap(1'b0, 1'b0, 0);
        controleer("toestand_normaal_30", 10'(toestand), 10'd1);

        // Averages 35, 40, 45, 50; HOOG only after 50.
        strobes(50, 4);
        controleer("gem_50", 10'(gemiddelde), 10'd50);
        stap(1'b0, 1'b0, 0);
        controleer("hoog_na_50", 10'(toestand), 10'd2);

        // In HOOG: averages down to 44 stay HOOG, 42 goes NORMAAL.
        strobes(44, 4);
        stap(1'b0, 1'b0, 0);
        controleer("hoog_bij_44", 10'(toestand), 10'd2);
        strobes(42, 4);
        stap(1'b0, 1'b0, 0);
        controleer("normaal_bij_42", 10'(toestand), 10'd1);

        // Three HOOG evaluations raise alarm; dropping to 40 clears it.
        strobes(50, 4);
        stap(1'b0, 1'b0, 0);
        controleer("alarm_na_3_hoog", 10'(alarm), 10'd1);
        stap(1'b0, 1'b1, 10);
        controleer("gem_40", 10'(gemiddelde), 10'd40);
        stap(1'b0, 1'b0, 0);
        controleer("normaal_na_40", 10'(toestand), 10'd1);
        controleer("alarm_uit_na_40", 10'(alarm), 10'd0);

        // Low rate with hysteresis on the way out.
        strobes(20, 4);
        strobes(27, 4);
        strobes(28, 4);
        stap(1'b0, 1'b0, 0);

        // Full-scale samples: no wrap of the running sum.
        strobes(255, 4);
        controleer("gem_255", 10'(gemiddelde), 10'd255);
        stap(1'b0, 1'b1, 0);
        controleer("gem_191", 10'(gemiddelde), 10'd191);
        stap(1'b0, 1'b0, 0);

        // Reset coincident with a strobe after two samples.
        strobes(33, 2);
        stap(1'b1, 1'b1, 99);
        controleer("reset_gem_0", 10'(gemiddelde), 10'd0);
        strobes(40, 3);
        controleer("geen_gem_vld_na_reset", 10'(gem_vld), 10'd0);
        stap(1'b0, 1'b1, 40);
        controleer("gem_vld_na_4_vers", 10'(gem_vld), 10'd1);

        // Random stimulus concentrated around the thresholds.
        for (int i = 0; i < 1500; i++) begin
            int r;
            int v;
            r = int'($urandom_range(0, 99));
            if (r < 8) v = int'($urandom_range(0, 255));
            else v = int'($urandom_range(15, 55));
            if (r == 99) stap(1'b1, ($urandom_range(0, 1) == 1), v);
            else stap(1'b0, (r < 70), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
